// File: rtl/ram_arbiter.sv
// Round-robin two-master RAM sequencer: IDLE -> ACCESS -> ACK, one-cycle active-low strobes,
// read-data capture and per-master ack/err. All outputs are registered.
module ram_arbiter #(
    parameter int unsigned MEM_BYTES = 256,
    parameter logic [7:0]  OOR_RDATA = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_addr,
    input  logic [7:0]  m0_wdata,
    output logic [7:0]  m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_addr,
    input  logic [7:0]  m1_wdata,
    output logic [7:0]  m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic        ram_cs_,
    output logic        ram_oe_,
    output logic        ram_we_,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_wdata_oe,
    input  logic [7:0]  ram_rdata,
    output logic        owner,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t      state_q;
    logic        last_q, owner_q, busy_q, wr_q, oor_q;
    logic        cs_q, oe_q, we_q, wdata_oe_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [1:0]  ack_q, err_q;
    logic [7:0]  rdata_q [2];

    logic        any_req, gnt_d, we_d, oor_d;
    logic [15:0] addr_d;
    logic [7:0]  wdata_d;

    // Contention goes to the master not served last; a lone requester always wins.
    always_comb begin
        any_req = m0_req | m1_req;
        if (m0_req && m1_req) gnt_d = ~last_q;
        else                  gnt_d = m1_req;
        we_d    = gnt_d ? m1_we    : m0_we;
        addr_d  = gnt_d ? m1_addr  : m0_addr;
        wdata_d = gnt_d ? m1_wdata : m0_wdata;
        oor_d   = {1'b0, addr_d} >= 17'(MEM_BYTES);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            busy_q     <= 1'b0;
            wr_q       <= 1'b0;
            oor_q      <= 1'b0;
            cs_q       <= 1'b1;
            oe_q       <= 1'b1;
            we_q       <= 1'b1;
            wdata_oe_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q    <= gnt_d;
                        last_q     <= gnt_d;
                        busy_q     <= 1'b1;
                        addr_q     <= addr_d;
                        wdata_q    <= wdata_d;
                        wr_q       <= we_d;
                        oor_q      <= oor_d;
                        // Strobes are set here so they are already low for the whole ACCESS cycle.
                        cs_q       <= oor_d;
                        oe_q       <= oor_d | we_d;
                        we_q       <= oor_d | ~we_d;
                        wdata_oe_q <= ~oor_d & we_d;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    cs_q           <= 1'b1;
                    oe_q           <= 1'b1;
                    we_q           <= 1'b1;
                    wdata_oe_q     <= 1'b0;
                    ack_q[owner_q] <= 1'b1;
                    err_q[owner_q] <= oor_q;
                    if (!wr_q) rdata_q[owner_q] <= oor_q ? OOR_RDATA : ram_rdata;
                    state_q        <= ACK;
                end
                ACK: begin
                    ack_q   <= '0;
                    err_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m0_rdata     = rdata_q[0];
    assign m1_rdata     = rdata_q[1];
    assign m0_ack       = ack_q[0];
    assign m1_ack       = ack_q[1];
    assign m0_err       = err_q[0];
    assign m1_err       = err_q[1];
    assign ram_cs_      = cs_q;
    assign ram_oe_      = oe_q;
    assign ram_we_      = we_q;
    assign ram_addr     = addr_q;
    assign ram_wdata    = wdata_q;
    assign ram_wdata_oe = wdata_oe_q;
    assign owner        = owner_q;
    assign busy         = busy_q;

endmodule
